// File: rtl/uart_pkg.sv
// Shared types and constants for the host-link UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int CLKS_PER_BIT_57600 = 1736;
  localparam int UART_DATA_BITS     = 8;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered pointers and first-word-fall-through output.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (count_r == DEPTH_CNT);
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // A push at full is refused outright, even if a pop frees a slot this cycle.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK100MHZ) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a START/DATA/STOP serialiser.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_57600,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        CLK100MHZ,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        Uart_TXD,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t  state_r, state_next_s;
  logic [BW-1:0] baud_r, baud_next_s;
  logic [2:0] bit_idx_r, bit_idx_next_s;
  logic [7:0] sh_r, sh_next_s;
  logic       txd_r, txd_s;
  logic       busy_r;
  logic       pop_s;
  logic       baud_done_s;
  logic [7:0] head_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .push      (tx_valid),
    .din       (tx_data),
    .pop       (pop_s),
    .dout      (head_s),
    .count     (fifo_count),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign tx_ready = !fifo_full_s;
  assign Uart_TXD = txd_r;
  assign tx_busy  = busy_r;

  // Next-state, baud counter and shifter; counter clears on every bit boundary.
  always_comb begin
    state_next_s   = state_r;
    baud_next_s    = baud_r;
    bit_idx_next_s = bit_idx_r;
    sh_next_s      = sh_r;
    pop_s          = 1'b0;
    baud_done_s    = (baud_r == BAUD_LAST);
    case (state_r)
      IDLE: begin
        baud_next_s    = BAUD_ZERO;
        bit_idx_next_s = 3'd0;
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          sh_next_s    = head_s;
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (baud_done_s) begin
          state_next_s   = DATA;
          baud_next_s    = BAUD_ZERO;
          bit_idx_next_s = 3'd0;
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_done_s) begin
          baud_next_s = BAUD_ZERO;
          if (bit_idx_r == BIT_LAST) begin
            state_next_s = STOP;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_done_s) begin
          state_next_s = IDLE;
          baud_next_s  = BAUD_ZERO;
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_next_s   = IDLE;
        baud_next_s    = BAUD_ZERO;
        bit_idx_next_s = 3'd0;
      end
    endcase
  end

  // Line level for the current state; registered below so the pin never glitches.
  always_comb begin
    case (state_r)
      IDLE:    txd_s = 1'b1;
      START:   txd_s = 1'b0;
      DATA:    txd_s = sh_r[bit_idx_r];
      STOP:    txd_s = 1'b1;
      default: txd_s = 1'b1;
    endcase
  end

  // Serialiser state and registered outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_r   <= IDLE;
      baud_r    <= BAUD_ZERO;
      bit_idx_r <= 3'd0;
      sh_r      <= 8'h00;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      baud_r    <= baud_next_s;
      bit_idx_r <= bit_idx_next_s;
      sh_r      <= sh_next_s;
      txd_r     <= txd_s;
      busy_r    <= (state_next_s != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: a slow (1736 clk/bit) and a fast (4 clk/bit) transmitter, each decoded by a UART RX model.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_s, rst_f;
  logic       vs, vf;
  logic [7:0] ds, df;
  logic       ready_s, ready_f;
  logic       txd_s, txd_f;
  logic       busy_s, busy_f;
  logic [4:0] count_s, count_f;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int peak = 0;
  int start0 = 0;
  int nframes [2];
  int starts1 [$];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  uart_tx_fifo #(.CLKS_PER_BIT(1736), .FIFO_DEPTH(16)) dut_slow (
    .CLK100MHZ(clk), .reset(rst_s), .tx_data(ds), .tx_valid(vs), .tx_ready(ready_s),
    .Uart_TXD(txd_s), .tx_busy(busy_s), .fifo_count(count_s)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut_fast (
    .CLK100MHZ(clk), .reset(rst_f), .tx_data(df), .tx_valid(vf), .tx_ready(ready_f),
    .Uart_TXD(txd_f), .tx_busy(busy_f), .fifo_count(count_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 0) ? txd_s : txd_f;
  endfunction

  function automatic logic rst_of(input int sel);
    return (sel == 0) ? rst_s : rst_f;
  endfunction

  // UART receiver model: every bit must hold for exactly cpb samples.
  task automatic rx_monitor(input int sel, input int cpb);
    logic v, bitv, bad, aborted;
    logic [7:0] data, exp;
    int st;
    forever begin
      @(negedge clk);
      if (line_of(sel) === 1'b0 && rst_of(sel) === 1'b0) begin
        st = cyc; bad = 1'b0; aborted = 1'b0; data = 8'h00; bitv = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int k = 0; k < cpb && !aborted; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst_of(sel) !== 1'b0) aborted = 1'b1;
            else begin
              v = line_of(sel);
              if (k == 0) bitv = v;
              else if (v !== bitv) bad = 1'b1;
            end
          end
          if (b == 0 && bitv !== 1'b0) bad = 1'b1;
          if (b == 9 && bitv !== 1'b1) bad = 1'b1;
          if (b >= 1 && b <= 8) data[b-1] = bitv;
        end
        if (!aborted) begin
          nframes[sel]++;
          if (sel == 0) start0 = st;
          else starts1.push_back(st);
          if ((sel == 0 && exp_q0.size() == 0) || (sel == 1 && exp_q1.size() == 0)) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_frame dut%0d: got %0h, expected no frame", sel, data);
          end else begin
            exp = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("rx_byte_dut%0d", sel), {24'h0, data}, {24'h0, exp});
            check($sformatf("rx_framing_dut%0d", sel), {31'h0, bad}, 32'h0);
          end
        end
      end
    end
  endtask

  initial rx_monitor(0, 1736);
  initial rx_monitor(1, 4);

  // Occupancy invariants of the fast instance, sampled every cycle.
  always @(negedge clk) begin
    if (rst_f === 1'b0 && cyc > 4) begin
      check("ready_vs_count", {31'h0, ready_f}, {31'h0, (count_f != 5'd16)});
      if (int'(count_f) > peak) peak = int'(count_f);
    end
  end

  task automatic push_fast(input logic [7:0] b);
    logic r;
    int guard;
    @(negedge clk);
    vf = 1'b1; df = b; guard = 0;
    forever begin
      r = ready_f;
      @(posedge clk);
      if (r) break;
      guard++;
      if (guard > 1000) begin
        check("push_timeout", 32'h0, 32'h1);
        break;
      end
      @(negedge clk);
    end
    if (r) exp_q1.push_back(b);
  endtask

  task automatic idle_fast();
    @(negedge clk);
    vf = 1'b0;
  endtask

  task automatic drain_fast(input int bound);
    int g;
    g = 0;
    while (!(exp_q1.size() == 0 && busy_f === 1'b0 && count_f === 5'd0 && txd_f === 1'b1) && g < bound) begin
      @(negedge clk); g++;
    end
    check("drain_in_time", {31'h0, (g < bound)}, 32'h1);
  endtask

  initial begin
    #3000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 3 ms");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    int push_cyc, n, g, base, gap;
    nframes[0] = 0; nframes[1] = 0;
    rst_s = 1'b1; rst_f = 1'b1; vs = 1'b0; vf = 1'b0; ds = 8'h00; df = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b0; rst_f = 1'b0;
    check("rst_txd_slow", {31'h0, txd_s}, 32'h1);
    check("rst_busy_slow", {31'h0, busy_s}, 32'h0);
    check("rst_count_slow", {27'h0, count_s}, 32'h0);
    check("rst_ready_slow", {31'h0, ready_s}, 32'h1);
    check("rst_txd_fast", {31'h0, txd_f}, 32'h1);
    check("rst_busy_fast", {31'h0, busy_f}, 32'h0);
    check("rst_count_fast", {27'h0, count_f}, 32'h0);
    check("rst_ready_fast", {31'h0, ready_f}, 32'h1);

    // Basic frame at full baud divisor.
    @(negedge clk);
    vs = 1'b1; ds = 8'h42;
    @(negedge clk);
    vs = 1'b0;
    push_cyc = cyc;
    exp_q0.push_back(8'h42);
    check("t1_count_after_push", {27'h0, count_s}, 32'h1);
    @(negedge clk);
    check("t1_count_after_pop", {27'h0, count_s}, 32'h0);
    n = 0;
    while (busy_s === 1'b1 && n < 20000) begin n++; @(negedge clk); end
    check("t1_busy_len", n, 17360);
    g = 0;
    while (nframes[0] < 1 && g < 5000) begin @(negedge clk); g++; end
    check("t1_frame_seen", nframes[0], 1);
    check("t1_latency", start0 - push_cyc, 2);

    // Back-to-back frames.
    peak = 0; starts1.delete(); base = nframes[1];
    push_fast(8'h00); push_fast(8'hFF); push_fast(8'hA5);
    idle_fast();
    drain_fast(1000);
    check("t2_peak", peak, 2);
    check("t2_frames", nframes[1] - base, 3);
    if (starts1.size() == 3) begin
      check("t2_period_a", starts1[1] - starts1[0], 41);
      check("t2_period_b", starts1[2] - starts1[1], 41);
    end else begin
      check("t2_start_count", starts1.size(), 3);
    end

    // Fill to full, then a push held against a same-cycle pop.
    peak = 0; base = nframes[1];
    for (int i = 0; i <= 16; i++) push_fast(8'(i));
    @(negedge clk);
    vf = 1'b1; df = 8'h11; g = 0;
    while (busy_f === 1'b1 && g < 500) begin @(negedge clk); g++; end
    check("t4_ready_low_at_full", {31'h0, ready_f}, 32'h0);
    check("t4_count_full", {27'h0, count_f}, 32'd16);
    @(negedge clk);
    check("t4_count_after_pop", {27'h0, count_f}, 32'd15);
    check("t4_ready_after_pop", {31'h0, ready_f}, 32'h1);
    exp_q1.push_back(8'h11);
    @(negedge clk);
    check("t4_count_refilled", {27'h0, count_f}, 32'd16);
    vf = 1'b0;
    drain_fast(2000);
    check("t3_peak", peak, 16);
    check("t3_frames", nframes[1] - base, 18);

    // Reset in the middle of DATA bit 3 with five bytes queued.
    for (int i = 0; i < 6; i++) push_fast(8'(8'h81 + i));
    idle_fast();
    g = 0;
    while (busy_f !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    repeat (17) @(negedge clk);
    check("t5_queued_before_reset", {27'h0, count_f}, 32'd5);
    rst_f = 1'b1;
    @(negedge clk);
    check("t5_txd_after_reset", {31'h0, txd_f}, 32'h1);
    check("t5_busy_after_reset", {31'h0, busy_f}, 32'h0);
    check("t5_count_after_reset", {27'h0, count_f}, 32'h0);
    exp_q1.delete();
    rst_f = 1'b0;
    base = nframes[1];
    push_fast(8'h3C);
    idle_fast();
    drain_fast(500);
    repeat (20) @(negedge clk);
    check("t5_single_frame", nframes[1] - base, 1);

    // Streaming with random gaps across pointer wrap.
    peak = 0; base = nframes[1];
    for (int i = 0; i < 40; i++) begin
      push_fast(8'(8'h60 + i));
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        idle_fast();
        repeat (gap - 1) @(negedge clk);
      end
    end
    idle_fast();
    drain_fast(5000);
    check("t6_frames", nframes[1] - base, 40);
    check("t6_peak_bounded", {31'h0, (peak <= 16)}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
